// File: rtl/mac_addr_sequencer_if.sv
// Job request and MAC drive bundle for mac_addr_sequencer; the requester uses master, the sequencer uses slave.
// Latency: none, wires only. Backpressure: none. SEQ_ABORT_EN adds abort/aborted.
interface mac_addr_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] stride_a;
    logic [ADDR_W-1:0] stride_b;
    logic [LEN_W-1:0]  length;
    logic              enable;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [ADDR_W-1:0] mem_addr_b;
    logic              clr_acc;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  elem_idx;

`ifdef SEQ_ABORT_EN
    logic abort;
    logic aborted;

    modport master (
        output start, base_a, base_b, stride_a, stride_b, length, abort,
        input  enable, mem_addr_a, mem_addr_b, clr_acc, busy, done, elem_idx, aborted
    );
    modport slave (
        input  start, base_a, base_b, stride_a, stride_b, length, abort,
        output enable, mem_addr_a, mem_addr_b, clr_acc, busy, done, elem_idx, aborted
    );
`else
    modport master (
        output start, base_a, base_b, stride_a, stride_b, length,
        input  enable, mem_addr_a, mem_addr_b, clr_acc, busy, done, elem_idx
    );
    modport slave (
        input  start, base_a, base_b, stride_a, stride_b, length,
        output enable, mem_addr_a, mem_addr_b, clr_acc, busy, done, elem_idx
    );
`endif
endinterface

// File: rtl/mac_addr_sequencer.sv
// Purpose: clears the mac_unit accumulator, then walks two strided operand vectors at the MAC's element cadence.
// Latency: done pulses 3N+3 cycles after start is accepted (1 cycle for N=0); all outputs registered.
// Backpressure: none; start is only honoured in IDLE. Optional SEQ_ABORT_EN adds abort/aborted.
module mac_addr_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int LEN_W       = 8,
    parameter int STEP_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_addr_sequencer_if.slave  bus
);
    localparam int                STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    // Latched at start so the requester may change its inputs mid-job.
    typedef struct packed {
        logic [ADDR_W-1:0] stride_a;
        logic [ADDR_W-1:0] stride_b;
        logic [LEN_W-1:0]  last_idx;
    } job_t;

    state_t            state;
    job_t              job;
    logic [STEP_W-1:0] step;
    logic              enable_q;
    logic              clr_acc_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [LEN_W-1:0]  elem_idx_q;

`ifdef SEQ_ABORT_EN
    logic aborted_q;
    logic abort_hit;
    assign abort_hit = bus.abort && (state == CLEAR || state == RUN || state == DRAIN);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            job        <= '0;
            step       <= '0;
            enable_q   <= 1'b0;
            clr_acc_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            elem_idx_q <= '0;
`ifdef SEQ_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            clr_acc_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        job    <= '{stride_a: bus.stride_a,
                                    stride_b: bus.stride_b,
                                    last_idx: bus.length - LEN_W'(1)};
                        if (bus.length == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state      <= CLEAR;
                            clr_acc_q  <= 1'b1;
                            addr_a_q   <= bus.base_a;
                            addr_b_q   <= bus.base_b;
                            elem_idx_q <= '0;
                        end
                    end
                end
                CLEAR: begin
                    state    <= RUN;
                    enable_q <= 1'b1;
                    step     <= '0;
                end
                RUN: begin
                    if (step == STEP_LAST) begin
                        step <= '0;
                        // Last element keeps its addresses so they hold after the job.
                        if (elem_idx_q == job.last_idx) begin
                            state    <= DRAIN;
                            enable_q <= 1'b0;
                        end else begin
                            addr_a_q   <= addr_a_q + job.stride_a;
                            addr_b_q   <= addr_b_q + job.stride_b;
                            elem_idx_q <= elem_idx_q + LEN_W'(1);
                        end
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
`ifdef SEQ_ABORT_EN
            if (abort_hit) begin
                state     <= IDLE;
                enable_q  <= 1'b0;
                clr_acc_q <= 1'b0;
                done_q    <= 1'b0;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.enable     = enable_q;
    assign bus.clr_acc    = clr_acc_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.mem_addr_a = addr_a_q;
    assign bus.mem_addr_b = addr_b_q;
    assign bus.elem_idx   = elem_idx_q;
`ifdef SEQ_ABORT_EN
    assign bus.aborted    = aborted_q;
`endif
endmodule
